cam_dvp_capture: RTL and testbench

Parameterised DVP camera capture stage that succeeds the fixed 8-bit-to-RGB565 capture path. It sits between the camera pins (after config completes) and the frame-buffer write FIFO, clocked by the camera pixel clock. It skips a programmable number of settling frames, assembles `BYTES_PER_PIX` bus beats into one pixel, and tracks x/y position. It can crop to a window, flags frame and line boundaries, and reports geometry errors.

---
 rtl/cam_dvp_capture_if.sv | 27 ++
 rtl/cam_dvp_capture.sv | 200 ++++++++++++++++++++
 tb/tb_cam_dvp_capture.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_dvp_capture_if.sv
// Camera-side and pixel-side signal bundle for cam_dvp_capture.
// slave: the capture block; master: whatever drives the camera pins and consumes pixels.
interface cam_dvp_capture_if #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2
);
  logic                              capture_en;
  logic                              cam_href;
  logic                              cam_vsync;
  logic [DATA_W-1:0]                 cam_data;
  logic                              pix_valid;
  logic [DATA_W*BYTES_PER_PIX-1:0]   pix_data;
  logic                              pix_sof;
  logic                              pix_eol;
  logic                              frame_done;
  logic                              geom_err;

  modport slave (
    input  capture_en, cam_href, cam_vsync, cam_data,
    output pix_valid, pix_data, pix_sof, pix_eol, frame_done, geom_err
  );

  modport master (
    output capture_en, cam_href, cam_vsync, cam_data,
    input  pix_valid, pix_data, pix_sof, pix_eol, frame_done, geom_err
  );
endinterface

// File: rtl/cam_dvp_capture.sv
// DVP capture: frame skip, beat-to-pixel assembly, x/y tracking, window, geometry checks.
// Optional macro CAM_CROP_EN enables cropping to the WIN_* window.
module cam_dvp_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int FRAME_SKIP    = 10,
  parameter int H_ACT         = 640,
  parameter int V_ACT         = 480,
  parameter int WIN_X0        = 0,
  parameter int WIN_Y0        = 0,
  parameter int WIN_W         = 640,
  parameter int WIN_H         = 480
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  cam_dvp_capture_if.slave  bus
);
  localparam int PW = DATA_W * BYTES_PER_PIX;
  // x/y must be able to hold H_ACT/V_ACT and one beyond so oversize is visible
  localparam int XW = $clog2(H_ACT + 2);
  localparam int YW = $clog2(V_ACT + 2);
  localparam int BW = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int SW = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;

`ifdef CAM_CROP_EN
  localparam int CX0 = WIN_X0;
  localparam int CY0 = WIN_Y0;
  localparam int CW  = WIN_W;
  localparam int CH  = WIN_H;
`else
  localparam int CX0 = 0;
  localparam int CY0 = 0;
  localparam int CW  = H_ACT;
  localparam int CH  = V_ACT;
`endif

  generate
    if (WIN_X0 + WIN_W > H_ACT || WIN_Y0 + WIN_H > V_ACT ||
        BYTES_PER_PIX < 1 || BYTES_PER_PIX > 4) begin : g_bad_cfg
      $error("cam_dvp_capture: window outside active area or bad BYTES_PER_PIX");
    end
  endgenerate

  localparam logic [XW-1:0] WX0   = XW'(CX0);
  localparam logic [XW-1:0] WXL   = XW'(CX0 + CW - 1);
  localparam logic [XW-1:0] WWX   = XW'(CW);
  localparam logic [YW-1:0] WY0   = YW'(CY0);
  localparam logic [YW-1:0] WHY   = YW'(CH);
  localparam logic [XW-1:0] HX    = XW'(H_ACT);
  localparam logic [YW-1:0] VY    = YW'(V_ACT);
  localparam logic [XW-1:0] XMAX  = '1;
  localparam logic [YW-1:0] YMAX  = '1;
  localparam logic [BW-1:0] BLAST = BW'(BYTES_PER_PIX - 1);
  localparam logic [SW-1:0] SKIPN = SW'(FRAME_SKIP);
  localparam logic [SW-1:0] SMAX  = '1;

  typedef enum logic [1:0] {IDLE, SKIP, ACTIVE} state_e;

  state_e          state_q, state_d;
  logic            href_q, vs_q, href_prev_q, vs_prev_q;
  logic [DATA_W-1:0] data_q;
  logic [SW-1:0]   skip_q, skip_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d, y_line;
  logic [PW-1:0]   acc_q, acc_d, asm_pix;
  logic            pv_q, pv_d, sof_q, sof_d, eol_q, eol_d, fd_q, fd_d, ge_q, ge_d;
  logic [PW-1:0]   pd_q, pd_d;
  logic            vs_rise, line_end, active, start, pix_done, in_win;
  logic            err_line, err_frame;
  logic [XW:0]     dx;
  logic [YW:0]     dy;

  assign vs_rise  = vs_q & ~vs_prev_q;
  assign line_end = href_prev_q & ~href_q;
  assign asm_pix  = (acc_q << DATA_W) | PW'(data_q);

  // borrow bit of the offset subtraction doubles as the "below origin" test
  assign dx     = {1'b0, x_q} - {1'b0, WX0};
  assign dy     = {1'b0, y_q} - {1'b0, WY0};
  assign in_win = ~dx[XW] & (dx[XW-1:0] < WWX) & ~dy[YW] & (dy[YW-1:0] < WHY);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.capture_en) state_d = SKIP;
      SKIP:    if (!bus.capture_en) state_d = IDLE;
               else if (vs_rise && skip_q == SKIPN) state_d = ACTIVE;
      ACTIVE:  if (vs_rise && !bus.capture_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == ACTIVE);
    start  = 1'b0;
    skip_d = skip_q;
    case (state_q)
      IDLE: begin
        skip_d = '0;
        start  = bus.capture_en;
      end
      SKIP:    if (vs_rise && skip_q != SMAX) skip_d = skip_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    beat_d    = '0;
    x_d       = '0;
    y_d       = '0;
    y_line    = y_q;
    acc_d     = href_q ? asm_pix : acc_q;
    pix_done  = active & href_q & (beat_q == BLAST);
    err_line  = 1'b0;
    err_frame = 1'b0;
    if (active) begin
      x_d = x_q;
      if (href_q) begin
        if (beat_q == BLAST) begin
          if (x_q != XMAX) x_d = x_q + 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      if (line_end) begin
        err_line = (x_q != HX) || (beat_q != '0);
        x_d      = '0;
        if (x_q != '0 && y_q != YMAX) y_line = y_q + 1'b1;
      end
      y_d = y_line;
      // frame end sees the line count including a line closing in this cycle
      if (vs_rise) begin
        err_frame = (y_line != VY);
        x_d       = '0;
        y_d       = '0;
        beat_d    = '0;
      end
    end
  end

  always_comb begin
    pv_d  = pix_done & in_win;
    pd_d  = pv_d ? asm_pix : pd_q;
    sof_d = pv_d & (x_q == WX0) & (y_q == WY0);
    eol_d = pv_d & (x_q == WXL);
    fd_d  = active & vs_rise;
    ge_d  = start ? 1'b0 : (ge_q | err_line | err_frame);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      href_q      <= 1'b0;
      vs_q        <= 1'b0;
      data_q      <= '0;
      href_prev_q <= 1'b0;
      vs_prev_q   <= 1'b0;
      skip_q      <= '0;
      beat_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      pv_q        <= 1'b0;
      pd_q        <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      fd_q        <= 1'b0;
      ge_q        <= 1'b0;
    end else begin
      href_q      <= bus.cam_href;
      vs_q        <= bus.cam_vsync;
      data_q      <= bus.cam_data;
      href_prev_q <= href_q;
      vs_prev_q   <= vs_q;
      skip_q      <= skip_d;
      beat_q      <= beat_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      pv_q        <= pv_d;
      pd_q        <= pd_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      fd_q        <= fd_d;
      ge_q        <= ge_d;
    end
  end

  assign bus.pix_valid  = pv_q;
  assign bus.pix_data   = pd_q;
  assign bus.pix_sof    = sof_q;
  assign bus.pix_eol    = eol_q;
  assign bus.frame_done = fd_q;
  assign bus.geom_err   = ge_q;
endmodule

// File: tb/tb_cam_dvp_capture.sv
// Directed bench for cam_dvp_capture on a 16x24 frame, two beats per pixel, two skipped frames.
// Expected pixels come from a frame-level model; per-cycle compare runs inside tick().
module tb_cam_dvp_capture;
  localparam int DW = 8, BPP = 2, H = 16, V = 24, FS = 2;
`ifdef CAM_CROP_EN
  localparam int X0 = 10, Y0 = 20, WW = 4, WH = 2;
  localparam int EXP_PIX = 8, EXP_EOL = 2;
`else
  localparam int X0 = 0, Y0 = 0, WW = 16, WH = 24;
  localparam int EXP_PIX = 384, EXP_EOL = 24;
`endif

  typedef struct {logic [15:0] d; bit sof; bit eol;} pix_t;
  pix_t exp_q[$];

  int total = 0, bad = 0, cyc = 0;
  int pv_cnt = 0, sof_cnt = 0, eol_cnt = 0, fd_cnt = 0;
  bit mdl_err = 0;
  logic clk = 1'b0, rst = 1'b1;

  always #5 clk = ~clk;

  cam_dvp_capture_if #(.DATA_W(DW), .BYTES_PER_PIX(BPP)) bus ();

  cam_dvp_capture #(
    .DATA_W(DW), .BYTES_PER_PIX(BPP), .FRAME_SKIP(FS), .H_ACT(H), .V_ACT(V),
    .WIN_X0(10), .WIN_Y0(20), .WIN_W(4), .WIN_H(2)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] beat(int fr, int ln, int b);
    if (fr == 99 && ln == 0 && b == 0) return 8'hA5;
    if (fr == 99 && ln == 0 && b == 1) return 8'h3C;
    return 8'(fr * 37 + ln * 11 + b * 3 + 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_pix(input int fr, input int ln, input int x, input int y);
    pix_t p;
    if (x >= X0 && x < X0 + WW && y >= Y0 && y < Y0 + WH) begin
      p.d   = {beat(fr, ln, 2 * x), beat(fr, ln, 2 * x + 1)};
      p.sof = (x == X0 && y == Y0);
      p.eol = (x == X0 + WW - 1);
      exp_q.push_back(p);
    end
  endtask

  // whole-frame view: pixels per line, line counting, geometry verdict
  task automatic model_frame(input int fr, input int sl, input int sb);
    int y = 0;
    for (int ln = 0; ln < V; ln++) begin
      int nb = (ln == sl) ? sb : 2 * H;
      int np = nb / BPP;
      for (int p = 0; p < np; p++) push_pix(fr, ln, p, y);
      if (np != H || nb % BPP != 0) mdl_err = 1;
      if (np > 0) y++;
    end
    if (y != V) mdl_err = 1;
  endtask

  task automatic tick();
    pix_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL cycle_budget: got %0d cycles want below 90000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    if (bus.pix_valid === 1'b1) begin
      pv_cnt++;
      if (bus.pix_sof === 1'b1) sof_cnt++;
      if (bus.pix_eol === 1'b1) eol_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pix_unexpected: got pixel %0h want none", bus.pix_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.pix_data, bus.pix_sof, bus.pix_eol} !== {e.d, e.sof, e.eol}) begin
          bad++;
          $display("FAIL pix_stream: got %0h sof%0b eol%0b want %0h sof%0b eol%0b",
                   bus.pix_data, bus.pix_sof, bus.pix_eol, e.d, e.sof, e.eol);
        end
      end
    end
    if (bus.frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic drive_vs(input bit exp_fd);
    bus.cam_vsync = 1'b1;
    tick();
    chk("fd_early", bus.frame_done, 0);
    tick();
    chk("fd_pulse", bus.frame_done, exp_fd);
    tick();
    chk("fd_clear", bus.frame_done, 0);
    bus.cam_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic drive_line(input int fr, input int ln, input int nb);
    bus.cam_href = 1'b1;
    for (int b = 0; b < nb; b++) begin
      bus.cam_data = beat(fr, ln, b);
      tick();
`ifndef CAM_CROP_EN
      if (fr == 99 && ln == 0 && b == 1) chk("lat_early", bus.pix_valid, 0);
      if (fr == 99 && ln == 0 && b == 2) begin
        chk("lat_valid", bus.pix_valid, 1);
        chk("lat_data", bus.pix_data, 32'hA53C);
      end
`endif
    end
    bus.cam_href = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drive_frame(input int fr, input int sl, input int sb, input int drop);
    for (int ln = 0; ln < V; ln++) begin
      if (ln == drop) bus.capture_en = 1'b0;
      drive_line(fr, ln, (ln == sl) ? sb : 2 * H);
    end
  endtask

  initial begin
    int pv0, sof0, eol0, fd0;
    bus.capture_en = 1'b0;
    bus.cam_href   = 1'b0;
    bus.cam_vsync  = 1'b0;
    bus.cam_data   = '0;
    tick();
    tick();
    chk("rst_valid", bus.pix_valid, 0);
    chk("rst_data", bus.pix_data, 0);
    chk("rst_sof", bus.pix_sof, 0);
    chk("rst_eol", bus.pix_eol, 0);
    chk("rst_fd", bus.frame_done, 0);
    chk("rst_geom", bus.geom_err, 0);
    rst = 1'b0;
    tick();

    // two skipped frames, third rise enters capture
    bus.capture_en = 1'b1;
    drive_vs(0); drive_frame(0, -1, 0, -1);
    drive_vs(0); drive_frame(1, -1, 0, -1);
    drive_vs(0);
    chk("skip_no_pix", pv_cnt, 0);
    pv0 = pv_cnt; sof0 = sof_cnt; eol0 = eol_cnt; fd0 = fd_cnt;
    model_frame(2, -1, 0);
    chk("model_pix", exp_q.size(), EXP_PIX);
    drive_frame(2, -1, 0, -1);
    drive_vs(1);
    chk("f_pix_cnt", pv_cnt - pv0, EXP_PIX);
    chk("f_sof_cnt", sof_cnt - sof0, 1);
    chk("f_eol_cnt", eol_cnt - eol0, EXP_EOL);
    chk("f_fd_cnt", fd_cnt - fd0, 1);
    chk("f_geom", bus.geom_err, 0);

    // A5/3C assembly and latency on line 0
    model_frame(99, -1, 0);
    drive_frame(99, -1, 0, -1);
    drive_vs(1);
    chk("d_geom", bus.geom_err, mdl_err);

    // short line: one beat missing leaves a partial pixel
    model_frame(3, 5, 2 * H - 1);
    chk("mdl_err_short", mdl_err, 1);
    drive_frame(3, 5, 2 * H - 1, -1);
    drive_vs(1);
    chk("geom_short", bus.geom_err, 1);
    model_frame(4, -1, 0);
    drive_frame(4, -1, 0, -1);
    drive_vs(1);
    chk("geom_sticky", bus.geom_err, mdl_err);

    // capture_en dropped mid-frame: frame completes, then idle
    fd0 = fd_cnt;
    model_frame(5, -1, 0);
    drive_frame(5, -1, 0, 10);
    drive_vs(1);
    chk("drop_fd", fd_cnt - fd0, 1);
    pv0 = pv_cnt;
    drive_frame(6, -1, 0, -1);
    drive_vs(0);
    chk("idle_no_pix", pv_cnt - pv0, 0);
    chk("idle_geom_held", bus.geom_err, 1);
    bus.capture_en = 1'b1;
    mdl_err = 0;
    tick();
    tick();
    chk("geom_cleared", bus.geom_err, 0);

    // reach capture again, then reset in the middle of line 0
    drive_vs(0); drive_frame(7, -1, 0, -1);
    drive_vs(0); drive_frame(8, -1, 0, -1);
    drive_vs(0);
    for (int p = 0; p < 3; p++) push_pix(12, 0, p, 0);
    bus.cam_href = 1'b1;
    for (int b = 0; b < 8; b++) begin
      bus.cam_data = beat(12, 0, b);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("mrst_valid", bus.pix_valid, 0);
    chk("mrst_data", bus.pix_data, 0);
    chk("mrst_sof", bus.pix_sof, 0);
    chk("mrst_eol", bus.pix_eol, 0);
    chk("mrst_fd", bus.frame_done, 0);
    chk("mrst_geom", bus.geom_err, 0);
    rst = 1'b0;
    bus.cam_href = 1'b0;
    tick();

    // restart must again wait FRAME_SKIP+1 rises
    pv0 = pv_cnt;
    drive_vs(0); drive_frame(13, -1, 0, -1);
    drive_vs(0); drive_frame(14, -1, 0, -1);
    drive_vs(0);
    chk("rskip_no_pix", pv_cnt - pv0, 0);
    model_frame(15, -1, 0);
    drive_frame(15, -1, 0, -1);
    drive_vs(1);
    chk("r_pix_cnt", pv_cnt - pv0, EXP_PIX);
    chk("r_geom", bus.geom_err, mdl_err);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
